// File: rtl/c_onehot_err_capture.sv
// One-hot violation monitor: pipelined multi/zero-hot detect, sticky flags, capture, count.
// Optional C_ERR_CAPTURE_TIMESTAMP_EN adds a cycle counter and err_ts capture.
module c_onehot_err_capture #(
  parameter int width       = 8,
  parameter int cnt_width   = 8,
  parameter bit require_one = 1'b0
`ifdef C_ERR_CAPTURE_TIMESTAMP_EN
  ,
  parameter int ts_width    = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 valid,
  input  logic [0:width-1]     data,
  input  logic                 clear,
  output logic                 err_multi_hot,
  output logic                 err_zero_hot,
  output logic                 err_pulse,
  output logic [0:width-1]     err_vec,
  output logic [0:cnt_width-1] err_count
`ifdef C_ERR_CAPTURE_TIMESTAMP_EN
  ,
  output logic [0:ts_width-1]  err_ts
`endif
);

  function automatic logic multi_hot(input logic [0:width-1] v);
    logic seen;
    logic mh;
    seen = 1'b0;
    mh   = 1'b0;
    for (int i = 0; i < width; i++) begin
      mh   = mh | (seen & v[i]);
      seen = seen | v[i];
    end
    return mh;
  endfunction

  logic             s1_valid;
  logic [0:width-1] s1_data;
  logic             captured;
  logic             mh;
  logic             zh;
  logic             viol;

  assign mh   = multi_hot(s1_data);
  assign zh   = ~|s1_data;
  assign viol = s1_valid & (mh | (require_one & zh));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (active) begin
      s1_valid <= valid;
      s1_data  <= data;
    end
  end

  // clear zeroes first; a same-edge violation then overrides it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pulse     <= 1'b0;
      err_multi_hot <= 1'b0;
      err_zero_hot  <= 1'b0;
      err_vec       <= '0;
      err_count     <= '0;
      captured      <= 1'b0;
    end else if (active) begin
      err_pulse <= viol;
      if (clear) begin
        err_multi_hot <= 1'b0;
        err_zero_hot  <= 1'b0;
        err_vec       <= '0;
        err_count     <= '0;
        captured      <= 1'b0;
      end
      if (viol) begin
        if (mh)
          err_multi_hot <= 1'b1;
        if (zh && require_one)
          err_zero_hot <= 1'b1;
        if (!captured || clear) begin
          err_vec  <= s1_data;
          captured <= 1'b1;
        end
        if (clear)
          err_count <= {{(cnt_width-1){1'b0}}, 1'b1};
        else if (err_count != '1)
          err_count <= err_count + 1'b1;
      end
    end
  end

`ifdef C_ERR_CAPTURE_TIMESTAMP_EN
  logic [0:ts_width-1] ts_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt <= '0;
      err_ts <= '0;
    end else if (active) begin
      ts_cnt <= ts_cnt + 1'b1;
      if (clear)
        err_ts <= '0;
      // +1: report the count as seen during the S2 cycle
      if (viol && (!captured || clear))
        err_ts <= ts_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_c_onehot_err_capture.sv
// Bench for c_onehot_err_capture: three configurations share one stimulus stream.
// Pulse expectations go through a scoreboard queue; sticky state uses a reference model.
module tb_c_onehot_err_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       active = 1'b0;
  logic       valid = 1'b0;
  logic [0:7] data = '0;
  logic       clear = 1'b0;

  logic       p0, mh0, zh0;
  logic       p1, mh1, zh1;
  logic       p2, mh2, zh2;
  logic [0:7] vec0, vec1, vec2;
  logic [0:7] cnt0, cnt1;
  logic [0:1] cnt2;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  c_onehot_err_capture #(.width(8), .cnt_width(8), .require_one(1'b0)) u0 (
    .clk(clk), .reset(rst_n), .active(active), .valid(valid),
    .data(data), .clear(clear), .err_multi_hot(mh0), .err_zero_hot(zh0),
    .err_pulse(p0), .err_vec(vec0), .err_count(cnt0)
  );

  c_onehot_err_capture #(.width(8), .cnt_width(8), .require_one(1'b1)) u1 (
    .clk(clk), .reset(rst_n), .active(active), .valid(valid),
    .data(data), .clear(clear), .err_multi_hot(mh1), .err_zero_hot(zh1),
    .err_pulse(p1), .err_vec(vec1), .err_count(cnt1)
  );

  c_onehot_err_capture #(.width(8), .cnt_width(2), .require_one(1'b0)) u2 (
    .clk(clk), .reset(rst_n), .active(active), .valid(valid),
    .data(data), .clear(clear), .err_multi_hot(mh2), .err_zero_hot(zh2),
    .err_pulse(p2), .err_vec(vec2), .err_count(cnt2)
  );

  int         req[3]  = '{0, 1, 0};
  int         cmax[3] = '{255, 255, 3};
  bit         m_mh[3];
  bit         m_zh[3];
  bit         m_cap[3];
  int         m_cnt[3];
  logic [0:7] m_vec[3];
  bit [2:0]   m_pulse;
  bit         prev_v;
  logic [0:7] prev_d;
  bit [2:0]   pq[$];

  function automatic bit viol_of(input bit v, input logic [0:7] d, input int k);
    return v && (($countones(d) > 1) || (req[k] != 0 && d == 8'h00));
  endfunction

  task automatic check(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("pulse", 0, 32'(p0), 32'(m_pulse[0]));
    check("pulse", 1, 32'(p1), 32'(m_pulse[1]));
    check("pulse", 2, 32'(p2), 32'(m_pulse[2]));
    check("multi", 0, 32'(mh0), 32'(m_mh[0]));
    check("multi", 1, 32'(mh1), 32'(m_mh[1]));
    check("multi", 2, 32'(mh2), 32'(m_mh[2]));
    check("zero", 0, 32'(zh0), 32'(m_zh[0]));
    check("zero", 1, 32'(zh1), 32'(m_zh[1]));
    check("zero", 2, 32'(zh2), 32'(m_zh[2]));
    check("vec", 0, 32'(vec0), 32'(m_vec[0]));
    check("vec", 1, 32'(vec1), 32'(m_vec[1]));
    check("vec", 2, 32'(vec2), 32'(m_vec[2]));
    check("count", 0, 32'(cnt0), 32'(m_cnt[0]));
    check("count", 1, 32'(cnt1), 32'(m_cnt[1]));
    check("count", 2, 32'(cnt2), 32'(m_cnt[2]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mh[k]  = 1'b0;
      m_zh[k]  = 1'b0;
      m_cap[k] = 1'b0;
      m_cnt[k] = 0;
      m_vec[k] = '0;
    end
    m_pulse = '0;
    prev_v  = 1'b0;
    prev_d  = '0;
    pq.delete();
    pq.push_back(3'b000);
  endtask

  task automatic model_edge(input bit v, input logic [0:7] d, input bit c);
    bit [2:0] nxt;
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        m_mh[k]  = 1'b0;
        m_zh[k]  = 1'b0;
        m_cap[k] = 1'b0;
        m_cnt[k] = 0;
        m_vec[k] = '0;
      end
      if (viol_of(prev_v, prev_d, k)) begin
        if ($countones(prev_d) > 1) m_mh[k] = 1'b1;
        if (prev_d == 8'h00 && req[k] != 0) m_zh[k] = 1'b1;
        if (!m_cap[k]) begin
          m_vec[k] = prev_d;
          m_cap[k] = 1'b1;
        end
        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
      end
      nxt[k] = viol_of(v, d, k);
    end
    prev_v = v;
    prev_d = d;
    pq.push_back(nxt);
    m_pulse = pq.pop_front();
  endtask

  task automatic step(input bit v, input logic [0:7] d, input bit c, input bit a);
    @(negedge clk);
    valid  = v;
    data   = d;
    clear  = c;
    active = a;
    @(posedge clk);
    #1;
    if (a) model_edge(v, d, c);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [0:7] d;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'b0010_0000, 1'b0, 1'b1);
    step(1'b1, 8'b0110_0000, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'b1000_0001, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'b1100_0000, 1'b0, 1'b1);
    step(1'b1, 8'b0000_0011, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'b0101_0000, 1'b0, 1'b1);
    step(1'b1, 8'b1111_0000, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'b0011_0000, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(3))
        0: d = 8'h00;
        1: d = 8'h01 << $urandom_range(7);
        default: d = 8'($urandom);
      endcase
      step(1'($urandom_range(1)), d,
           ($urandom_range(9) == 0), ($urandom_range(7) != 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
